if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the MIPS datapath/decode stage.
- Owns the fetch PC and drives the instruction-memory request interface. Memory latency is variable, with at most one request outstanding.
- Buffers returned instructions in a small prefetch queue and hands {inst, pc, pc+4} downstream with a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue and discarding any in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC after reset (bits [1:0] must be 0)
QDEPTH, 2, prefetch queue entries; power of two, >= 2

Ports:
clk  in  1  main clock, rising edge
cpu_rst_n  in  1  asynchronous active-low reset
cpu_en  in  1  global enable; 0 gates issue, pop and redirect
inst_ren  out  1  instruction read request (combinational)
inst_addr  out  32  fetch address, valid when inst_ren=1
inst_ack  in  1  memory returns data for the outstanding request this cycle
inst_data  in  32  instruction word, valid when inst_ack=1
redirect_valid  in  1  PC redirect (taken branch / jump / jr) from downstream
redirect_pc  in  32  redirect target
id_ready  in  1  downstream accepts the head instruction this cycle
if_valid  out  1  head instruction valid
if_inst  out  32  head instruction word
if_pc  out  32  address of head instruction
if_pc_4  out  32  if_pc + 4, mod 2^32

Behaviour:
- Reset (cpu_rst_n=0, asynchronous):
  - fetch_pc=RESET_PC, queue empty, state=S_RUN.
  - inst_ren=0, if_valid=0, if_inst=0, if_pc=0, if_pc_4=0, inst_addr=RESET_PC.
  - Outputs reach these values immediately, including mid-transaction.
- States:
  - S_RUN: no request outstanding.
  - S_WAIT: request outstanding; its data will be kept.
  - S_DROP: request outstanding; its data will be discarded.
- Issue:
  - inst_ren = cpu_en & ~redirect_valid & space & (state==S_RUN | (state==S_WAIT & inst_ack)).
  - space: occupancy after this cycle's write/pop < QDEPTH.
  - Memory samples inst_addr=fetch_pc on any cycle with inst_ren=1.
  - On issue: fetch_pc += 4 (wraps 0xFFFF_FFFC -> 0); state -> S_WAIT.
- Responses:
  - S_WAIT & inst_ack: write {inst_data, pc} into the queue; state -> S_RUN unless a new request issued the same cycle.
  - S_DROP & inst_ack: data discarded; state -> S_RUN. No issue occurs in that cycle.
  - inst_ack in S_RUN (stale, e.g. after reset): ignored.
  - inst_ack is processed regardless of cpu_en, because memory does not stall.
- Redirect (cpu_en & redirect_valid in cycle t):
  - Queue cleared; fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - if_valid forced 0 in cycle t; no pop and no issue in t.
  - S_WAIT without ack -> S_DROP; S_WAIT with ack -> data discarded, S_RUN; S_DROP stays S_DROP unless acked.
  - Redirect has priority over pop, queue write and issue.
- Output:
  - if_valid = queue non-empty & ~(cpu_en & redirect_valid).
  - if_inst, if_pc and if_pc_4 come from the queue head; fields retain stored values while invalid.
  - Pop when if_valid & id_ready & cpu_en.
  - Simultaneous pop and write is legal at any occupancy, including full.
- Latency: ack in cycle t -> if_valid in t+1 (no bypass).
- Throughput: with 1-cycle memory and id_ready=1, one instruction per cycle in steady state.
- Queue order is strictly FIFO; no overflow is possible because issue reserves a slot.

Decomposition:
- Shared package (mips_define): state encoding S_RUN/S_WAIT/S_DROP, default RESET_PC.
- One natural sub-module: if_queue, a QDEPTH-entry synchronous FIFO of {pc[31:0], inst[31:0]}. It has wr/rd/clr and full/empty, with async active-low reset.
- Issue logic, PC register and FSM stay in if_stage.

Test Plan:
- Reset release, cpu_en=1, memory acks 1 cycle after each request, id_ready=1 -> inst_addr 0x0,0x4,0x8 on consecutive cycles; if_valid first high 2 cycles after first request with if_pc=0x0, if_pc_4=0x4, if_inst=word at 0x0.
- id_ready=0 after first request -> queue fills to 2, inst_ren low, no further requests. Raise id_ready -> instructions 0x0,0x4 delivered in order, then fetch resumes at 0x8.
- Request at 0x8 outstanding (no ack), redirect_pc=0x100 -> S_DROP; ack 3 cycles later is discarded, never seen at if_inst; next inst_addr=0x100 the cycle after that ack.
- redirect_valid in the same cycle as inst_ack -> acked word discarded, if_valid=0 that cycle; inst_addr=0x100 with inst_ren=1 the next cycle.
- redirect_pc=0xFFFF_FFFE -> first fetch 0xFFFF_FFFC, if_pc_4=0x0, next inst_addr=0x0.
- cpu_rst_n low asynchronously while in S_WAIT with 2 queued entries -> if_valid=0, inst_ren=0 immediately. Stale inst_ack after release is ignored; first request is at RESET_PC.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// prefetch-queue entry layout and the default reset PC.
package mips_define;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_e;

   // pc_4 is stored rather than recomputed so the head fields read 0 after reset
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_4;
      logic [31:0] inst;
   } if_entry_t;

endpackage

// File: rtl/if_stage_if.sv
// Bus bundle between the fetch stage, instruction memory and decode.
// Handshakes: memory samples inst_addr whenever inst_ren=1 (no back-pressure) and
// answers later with one inst_ack pulse; decode takes the head when if_valid & id_ready.
interface if_stage_if;

   logic        inst_ren;
   logic [31:0] inst_addr;
   logic        inst_ack;
   logic [31:0] inst_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        if_valid;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic [31:0] if_pc_4;

   modport master (
      output inst_ren, inst_addr, if_valid, if_inst, if_pc, if_pc_4,
      input  inst_ack, inst_data, redirect_valid, redirect_pc, id_ready
   );

   modport slave (
      input  inst_ren, inst_addr, if_valid, if_inst, if_pc, if_pc_4,
      output inst_ack, inst_data, redirect_valid, redirect_pc, id_ready
   );

endinterface

// File: rtl/if_queue.sv
// Small synchronous FIFO holding fetched {pc, pc+4, inst} entries; clr_i
// empties it in one cycle and takes priority over read and write.
module if_queue
   import mips_define::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   clr_i,
   input  logic                   wr_i,
   input  if_entry_t              wr_data_i,
   input  logic                   rd_i,
   output if_entry_t              rd_data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   if_entry_t         mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q;
   logic [PW-1:0]     rd_ptr_q;
   logic [CW-1:0]     count_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (rd_i) rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(wr_i) - CW'(rd_i);
      end
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == CW'(DEPTH));
   assign count_o   = count_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one memory request
// in flight, buffers responses in a prefetch queue and handles redirects.
module if_stage
   import mips_define::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        cpu_rst_n,
   input  logic        cpu_en,
   if_stage_if.master  bus,
   output state_e      dbg_state_o
);

   localparam int CW = $clog2(QDEPTH) + 1;

   state_e        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          redir;
   logic          ack_wait;
   logic          q_wr;
   logic          pop;
   logic          space;
   logic          ren;
   logic [CW-1:0] q_count;
   logic [CW-1:0] occ_next;
   logic          q_full;
   logic          q_empty;
   if_entry_t     q_wdata;
   if_entry_t     q_head;

   assign redir    = cpu_en & bus.redirect_valid;
   assign ack_wait = (state_q == S_WAIT) & bus.inst_ack;
   assign q_wr     = ack_wait & ~redir;

   assign bus.if_valid = ~q_empty & ~redir;
   assign pop          = bus.if_valid & bus.id_ready & cpu_en;

   // Issue only if the response of the new request is guaranteed a slot
   assign occ_next = q_count + CW'(q_wr) - CW'(pop);
   assign space    = (occ_next < CW'(QDEPTH));
   assign ren      = cpu_rst_n & cpu_en & ~bus.redirect_valid & space
                     & ((state_q == S_RUN) | ack_wait);

   assign bus.inst_ren  = ren;
   assign bus.inst_addr = fetch_pc_q;

   // In S_WAIT the fetch PC has already advanced past the outstanding request
   assign q_wdata = if_entry_t'{pc: fetch_pc_q - 32'd4, pc_4: fetch_pc_q, inst: bus.inst_data};

   assign bus.if_inst = q_head.inst;
   assign bus.if_pc   = q_head.pc;
   assign bus.if_pc_4 = q_head.pc_4;
   assign dbg_state_o = state_q;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      if (redir) begin
         fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
         if (state_q != S_RUN) state_d = bus.inst_ack ? S_RUN : S_DROP;
      end else if (ren) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
         state_d    = S_WAIT;
      end else if ((state_q != S_RUN) && bus.inst_ack) begin
         state_d = S_RUN;
      end
   end

   always_ff @(posedge clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state_q    <= S_RUN;
         fetch_pc_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

   if_queue #(.DEPTH(QDEPTH)) u_queue (
      .clk_i     (clk),
      .rst_ni    (cpu_rst_n),
      .clr_i     (redir),
      .wr_i      (q_wr),
      .wr_data_i (q_wdata),
      .rd_i      (pop),
      .rd_data_o (q_head),
      .full_o    (q_full),
      .empty_o   (q_empty),
      .count_o   (q_count)
   );

   no_overflow: assert property (@(posedge clk) disable iff (!cpu_rst_n)
      !(q_wr && q_full && !pop));

endmodule
